hnoc_param_switch: RTL and testbench

//  Parametrised single-clock HNoC switch node; successor to the fixed 4-PE leaf.

---
 rtl/hnoc_param_switch_if.sv | 39 +++
 rtl/hnoc_param_switch.sv | 171 +++++++++++++++++
 tb/tb_hnoc_param_switch.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hnoc_param_switch_if.sv
// ---------------------------------------------------------------------------
// hnoc_param_switch_if
//   Bundles the per-port flit buses of one switch node. Every vector carries
//   all P ports: port p occupies slice [p*FW +: FW] of the data vectors and
//   bit [p] of the valid/ready vectors.
//
//   Handshake: a flit moves across a link on a rising clock edge exactly when
//   valid and ready are both high at that edge. Ready never depends on valid
//   in the same cycle. An egress flit, once valid, stays valid with stable
//   data until it is taken.
//
//   Signals (names are seen from the switch side):
//     i_data / i_data_valid / o_data_ready : ingress flits into the switch
//     o_data / o_data_valid / i_data_ready : egress flits out of the switch
//   Modports:
//     slave  : the switch node
//     master : whatever feeds and drains the node (PEs, parent, bench)
// ---------------------------------------------------------------------------
interface hnoc_param_switch_if #(
  parameter int P  = 5,
  parameter int FW = 35
);
  logic [P*FW-1:0] i_data;
  logic [P-1:0]    i_data_valid;
  logic [P-1:0]    o_data_ready;
  logic [P*FW-1:0] o_data;
  logic [P-1:0]    o_data_valid;
  logic [P-1:0]    i_data_ready;

  modport slave (
    input  i_data, i_data_valid, i_data_ready,
    output o_data_ready, o_data, o_data_valid
  );

  modport master (
    output i_data, i_data_valid, i_data_ready,
    input  o_data_ready, o_data, o_data_valid
  );
endinterface

// File: rtl/hnoc_param_switch.sv
// ---------------------------------------------------------------------------
// hnoc_param_switch
//   Single-clock HNoC switch node with NUM_LOCAL processing-element ports and
//   one uplink port (index NUM_LOCAL) toward the parent node. Single-flit
//   packets {dest, payload} are buffered in a per-input FIFO, routed by
//   destination address and forwarded through a round-robin arbiter and an
//   output register per output port.
//
//   Ports:
//     i_clk        : clock, rising edge
//     i_reset_n    : asynchronous active-low reset
//     bus          : flit buses for all ports (slave side)
//     o_drop_count : saturating count of uplink flits whose destination is
//                    not owned by this node
// ---------------------------------------------------------------------------
module hnoc_param_switch #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 3,
  parameter int NUM_LOCAL  = 4,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  hnoc_param_switch_if.slave   bus,
  output logic [15:0]          o_drop_count
);

  localparam int P  = NUM_LOCAL + 1;
  localparam int FW = DataWidth + AddrWidth;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(P);

  // ---------------- state ----------------
  logic [FW-1:0] mem_q      [P][FIFO_DEPTH];
  logic [FW-1:0] mem_d      [P][FIFO_DEPTH];
  logic [PW:0]   wr_ptr_q   [P];
  logic [PW:0]   wr_ptr_d   [P];
  logic [PW:0]   vis_ptr_q  [P];
  logic [PW:0]   vis_ptr_d  [P];
  logic [PW:0]   rd_ptr_q   [P];
  logic [PW:0]   rd_ptr_d   [P];
  logic [IW-1:0] rr_q       [P];
  logic [IW-1:0] rr_d       [P];
  logic [FW-1:0] out_data_q [P];
  logic [FW-1:0] out_data_d [P];
  logic [P-1:0]  out_valid_q, out_valid_d;
  logic          rdy_en_q, rdy_en_d;
  logic [15:0]   drop_q, drop_d;

  // ---------------- per-input status ----------------
  logic [P-1:0]  full, empty, is_local, drop, push, pop, ready;
  logic [FW-1:0] head  [P];
  logic [IW-1:0] route [P];
  logic [AddrWidth-1:0] dest [P];

  // The FIFO write pointer is mirrored one cycle late into vis_ptr; the
  // head side only sees entries up to vis_ptr. This gives the two-edge
  // minimum latency from acceptance to egress without costing throughput.
  // Full is judged against the real write pointer so no entry is overrun.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      full[p]     = (wr_ptr_q[p][PW] != rd_ptr_q[p][PW]) &&
                    (wr_ptr_q[p][PW-1:0] == rd_ptr_q[p][PW-1:0]);
      empty[p]    = (vis_ptr_q[p] == rd_ptr_q[p]);
      head[p]     = mem_q[p][rd_ptr_q[p][PW-1:0]];
      dest[p]     = head[p][FW-1 -: AddrWidth];
      is_local[p] = (int'(dest[p]) >= BASE_ADDR) &&
                    (int'(dest[p]) <  BASE_ADDR + NUM_LOCAL);
      route[p]    = is_local[p] ? IW'(int'(dest[p]) - BASE_ADDR) : IW'(NUM_LOCAL);
      // Only the uplink can carry an address this node does not own toward
      // the leaves; such a flit is discarded as soon as it reaches the head.
      drop[p]     = (p == NUM_LOCAL) && !empty[p] && !is_local[p];
      // Ready is held low until the first edge after reset release.
      ready[p]    = rdy_en_q && !full[p];
      push[p]     = bus.i_data_valid[p] && ready[p];
    end
  end

  // ---------------- arbitration and output registers ----------------
  logic          found;
  logic [IW-1:0] win;
  int            idx;

  always_comb begin
    pop         = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rr_d        = rr_q;
    found       = 1'b0;
    win         = '0;
    idx         = 0;
    for (int o = 0; o < P; o++) begin
      found = 1'b0;
      win   = '0;
      if (!out_valid_q[o] || bus.i_data_ready[o]) begin
        out_valid_d[o] = 1'b0;
        // Search starts at the round-robin pointer and wraps once.
        for (int k = 0; k < P; k++) begin
          idx = (int'(rr_q[o]) + k) % P;
          if (!found && !empty[idx] && !drop[idx] && (route[idx] == IW'(o))) begin
            found = 1'b1;
            win   = IW'(idx);
          end
        end
        if (found) begin
          out_valid_d[o] = 1'b1;
          out_data_d[o]  = head[win];
          pop[win]       = 1'b1;
          rr_d[o]        = (int'(win) == P - 1) ? '0 : win + 1'b1;
        end
      end
    end
  end

  // ---------------- pointer / memory / counter next state ----------------
  always_comb begin
    mem_d    = mem_q;
    rdy_en_d = 1'b1;
    drop_d   = drop_q;
    for (int p = 0; p < P; p++) begin
      if (push[p]) begin
        mem_d[p][wr_ptr_q[p][PW-1:0]] = bus.i_data[p*FW +: FW];
      end
      wr_ptr_d[p]  = wr_ptr_q[p] + (PW+1)'(push[p]);
      vis_ptr_d[p] = wr_ptr_q[p];
      rd_ptr_d[p]  = rd_ptr_q[p] + (PW+1)'(pop[p] || drop[p]);
    end
    if (drop[NUM_LOCAL] && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int p = 0; p < P; p++) begin
        wr_ptr_q[p]   <= '0;
        vis_ptr_q[p]  <= '0;
        rd_ptr_q[p]   <= '0;
        rr_q[p]       <= '0;
        out_data_q[p] <= '0;
      end
      out_valid_q <= '0;
      rdy_en_q    <= 1'b0;
      drop_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      vis_ptr_q   <= vis_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rr_q        <= rr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      rdy_en_q    <= rdy_en_d;
      drop_q      <= drop_d;
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  // ---------------- outputs ----------------
  for (genvar g = 0; g < P; g++) begin : g_out
    assign bus.o_data[g*FW +: FW] = out_data_q[g];
  end
  assign bus.o_data_valid = out_valid_q;
  assign bus.o_data_ready = ready;
  assign o_drop_count     = drop_q;

endmodule

// File: tb/tb_hnoc_param_switch.sv
// ---------------------------------------------------------------------------
// tb_hnoc_param_switch
//   Self-checking bench for hnoc_param_switch with default parameters.
//   Payload layout used by the bench: [31:28] source port, [27:0] sequence.
// ---------------------------------------------------------------------------
module tb_hnoc_param_switch;
  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int NL    = 4;
  localparam int BASE  = 0;
  localparam int DEPTH = 4;
  localparam int P     = NL + 1;
  localparam int FW    = DW + AW;
  localparam int N_RANDOM = 10000;

  typedef struct {
    logic [FW-1:0] flit;
    int            src;
    int            port;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  hnoc_param_switch_if #(.P(P), .FW(FW)) bus ();

  hnoc_param_switch #(
    .DataWidth(DW), .AddrWidth(AW), .NUM_LOCAL(NL),
    .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .bus         (bus),
    .o_drop_count(drop_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference helpers ----------------
  function automatic logic [FW-1:0] mk(int dest, logic [DW-1:0] pl);
    return {AW'(dest), pl};
  endfunction

  // Output port a flit should leave on, or -1 when it must be dropped.
  function automatic int ref_port(int src, int dest);
    if (dest >= BASE && dest < BASE + NL) return dest - BASE;
    if (src == NL) return -1;
    return NL;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_data       = '0;
    bus.i_data_valid = '0;
    bus.i_data_ready = '1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (bus.o_data_valid !== '0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.o_data_valid);
    end
    n_checks++;
    if (bus.o_data !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", bus.o_data);
    end
    n_checks++;
    if (bus.o_data_ready !== '0) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.o_data_ready);
    end
    n_checks++;
    if (drop_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_count);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.o_data_ready !== '0) begin
      n_fail++; $display("FAIL ready_before_edge: got %b expected 0", bus.o_data_ready);
    end
    tick();
    n_checks++;
    if (bus.o_data_ready !== {P{1'b1}}) begin
      n_fail++; $display("FAIL ready_after_edge: got %b expected all ones", bus.o_data_ready);
    end
  endtask

  task automatic test_single();
    logic [FW-1:0] f;
    apply_reset();
    f = mk(2, 32'hA5);
    bus.i_data[1*FW +: FW] = f;
    bus.i_data_valid[1]    = 1'b1;
    n_checks++;
    if (bus.o_data_ready[1] !== 1'b1) begin
      n_fail++; $display("FAIL single_ingress_ready: got %b expected 1", bus.o_data_ready[1]);
    end
    tick();                       // accepted on this edge
    bus.i_data_valid[1] = 1'b0;
    tick();                       // one edge later: not yet out
    n_checks++;
    if (bus.o_data_valid !== '0) begin
      n_fail++; $display("FAIL single_too_early: got %b expected 0", bus.o_data_valid);
    end
    tick();                       // two edges later: on output 2
    n_checks++;
    if (bus.o_data_valid !== 5'b00100) begin
      n_fail++; $display("FAIL single_valid: got %b expected 00100", bus.o_data_valid);
    end
    n_checks++;
    if (bus.o_data[2*FW +: FW] !== f) begin
      n_fail++; $display("FAIL single_data: got %h expected %h", bus.o_data[2*FW +: FW], f);
    end
    tick();
    n_checks++;
    if (bus.o_data_valid !== '0) begin
      n_fail++; $display("FAIL single_consumed: got %b expected 0", bus.o_data_valid);
    end
  endtask

  task automatic test_rr();
    int seq[P] = '{default: 0};
    int got_src[$];
    int got_cyc[$];
    int exp_src[6] = '{0, 1, 3, 0, 1, 3};
    logic [FW-1:0] f;
    apply_reset();
    for (int c = 0; c < 40 && got_src.size() < 6; c++) begin
      if (bus.o_data_valid[2]) begin
        f = bus.o_data[2*FW +: FW];
        got_src.push_back(int'(f[DW-1 -: 4]));
        got_cyc.push_back(c);
      end
      for (int p = 0; p < 4; p++) begin
        if (p != 2) begin
          bus.i_data_valid[p]    = 1'b1;
          bus.i_data[p*FW +: FW] = mk(2, {4'(p), 28'(seq[p])});
          if (bus.o_data_ready[p]) seq[p]++;
        end
      end
      tick();
    end
    idle_inputs();
    n_checks++;
    if (got_src.size() < 6) begin
      n_fail++; $display("FAIL rr_timeout: got %0d flits expected 6", got_src.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (got_src[i] != exp_src[i]) begin
          n_fail++; $display("FAIL rr_order[%0d]: got src %0d expected %0d", i, got_src[i], exp_src[i]);
        end
        n_checks++;
        if (got_cyc[i] != got_cyc[0] + i) begin
          n_fail++; $display("FAIL rr_rate[%0d]: got cycle %0d expected %0d", i, got_cyc[i], got_cyc[0] + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int got = 0;
    logic [FW-1:0] f;
    apply_reset();
    bus.i_data_ready[2] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!bus.o_data_ready[0]) break;
      bus.i_data_valid[0]    = 1'b1;
      bus.i_data[0*FW +: FW] = mk(2, 32'(100 + acc));
      acc++;
      tick();
    end
    bus.i_data_valid[0] = 1'b0;
    n_checks++;
    if (acc != DEPTH + 1) begin
      n_fail++; $display("FAIL bp_accept_count: got %0d expected %0d", acc, DEPTH + 1);
    end
    n_checks++;
    if (bus.o_data_ready[0] !== 1'b0) begin
      n_fail++; $display("FAIL bp_ready_low: got %b expected 0", bus.o_data_ready[0]);
    end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (bus.o_data_valid[2] !== 1'b1 || bus.o_data[2*FW +: FW] !== mk(2, 32'd100)) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%h expected v=1 d=%h",
                           c, bus.o_data_valid[2], bus.o_data[2*FW +: FW], mk(2, 32'd100));
      end
      tick();
    end
    bus.i_data_ready[2] = 1'b1;
    for (int c = 0; c < 20 && got < DEPTH + 1; c++) begin
      if (bus.o_data_valid[2]) begin
        f = bus.o_data[2*FW +: FW];
        n_checks++;
        if (f !== mk(2, 32'(100 + got))) begin
          n_fail++; $display("FAIL bp_drain[%0d]: got %h expected %h", got, f, mk(2, 32'(100 + got)));
        end
        got++;
      end
      tick();
    end
    n_checks++;
    if (got != DEPTH + 1) begin
      n_fail++; $display("FAIL bp_drain_count: got %0d expected %0d", got, DEPTH + 1);
    end
    n_checks++;
    if (bus.o_data_ready[0] !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready_back: got %b expected 1", bus.o_data_ready[0]);
    end
  endtask

  task automatic test_routing_and_drop();
    int c_src[6] = '{0, 4, 2, 0, 1, 3};
    int c_dst[6] = '{7, 1, 3, 4, 1, 0};
    int c_exp[6] = '{4, 1, 3, 4, 1, 0};
    int d_dst[2] = '{7, 4};
    logic [FW-1:0] f;
    logic [P-1:0]  exp_v;
    bit seen;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      f = mk(c_dst[i], 32'(32'h1000 + i));
      bus.i_data[c_src[i]*FW +: FW] = f;
      bus.i_data_valid[c_src[i]]    = 1'b1;
      tick();
      bus.i_data_valid = '0;
      seen  = 1'b0;
      exp_v = '0;
      exp_v[c_exp[i]] = 1'b1;
      for (int c = 0; c < 6 && !seen; c++) begin
        if (bus.o_data_valid != '0) begin
          seen = 1'b1;
          n_checks++;
          if (bus.o_data_valid !== exp_v || bus.o_data[c_exp[i]*FW +: FW] !== f) begin
            n_fail++; $display("FAIL route[%0d]: got v=%b d=%h expected v=%b d=%h",
                               i, bus.o_data_valid, bus.o_data[c_exp[i]*FW +: FW], exp_v, f);
          end
        end
        tick();
      end
      n_checks++;
      if (!seen) begin
        n_fail++; $display("FAIL route_timeout[%0d]: got nothing expected flit on port %0d", i, c_exp[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      bus.i_data[NL*FW +: FW] = mk(d_dst[i], 32'hDEAD);
      bus.i_data_valid[NL]    = 1'b1;
      tick();
      bus.i_data_valid = '0;
      seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
        if (bus.o_data_valid != '0) seen = 1'b1;
        tick();
      end
      n_checks++;
      if (seen) begin
        n_fail++; $display("FAIL drop_leak[%0d]: got a valid output expected none", i);
      end
      n_checks++;
      if (drop_count !== 16'(i + 1)) begin
        n_fail++; $display("FAIL drop_count[%0d]: got %0d expected %0d", i, drop_count, i + 1);
      end
    end
  endtask

  task automatic test_reset_midflight();
    bit seen = 1'b0;
    apply_reset();
    bus.i_data_ready = '0;
    for (int p = 0; p < 3; p++) begin
      bus.i_data[p*FW +: FW] = mk(3, 32'(32'h2000 + p));
      bus.i_data_valid[p]    = 1'b1;
    end
    tick();
    bus.i_data_valid = '0;
    repeat (3) tick();
    n_checks++;
    if (bus.o_data_valid[3] !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre: got %b expected 1", bus.o_data_valid[3]);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.o_data_valid !== '0 || bus.o_data !== '0) begin
      n_fail++; $display("FAIL midrst_async: got v=%b d=%h expected 0", bus.o_data_valid, bus.o_data);
    end
    n_checks++;
    if (bus.o_data_ready !== '0) begin
      n_fail++; $display("FAIL midrst_ready: got %b expected 0", bus.o_data_ready);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.o_data_ready !== '0) begin
      n_fail++; $display("FAIL midrst_ready_early: got %b expected 0", bus.o_data_ready);
    end
    tick();
    n_checks++;
    if (bus.o_data_ready !== {P{1'b1}}) begin
      n_fail++; $display("FAIL midrst_ready_edge: got %b expected all ones", bus.o_data_ready);
    end
    bus.i_data_ready = '1;
    for (int c = 0; c < 8; c++) begin
      if (bus.o_data_valid != '0) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL midrst_stale: got a stale flit expected none");
    end
  endtask

  task automatic test_random();
    exp_t          exp_q[$];
    logic [FW-1:0] pend_flit[P];
    logic [FW-1:0] prev_data[P];
    logic [P-1:0]  has_pend, rdy, prev_hold;
    logic [FW-1:0] f;
    int created = 0;
    int injected = 0;
    int drop_exp = 0;
    int seq = 0;
    int s, idx, rp;
    bit done = 1'b0;
    apply_reset();
    has_pend  = '0;
    prev_hold = '0;
    rdy       = '0;
    for (int p = 0; p < P; p++) begin
      pend_flit[p] = '0;
      prev_data[p] = '0;
    end
    for (int cyc = 0; cyc < 60000 && !done; cyc++) begin
      for (int o = 0; o < P; o++) rdy[o] = ($urandom_range(0, 3) != 0);
      bus.i_data_ready = rdy;
      // egress side
      for (int o = 0; o < P; o++) begin
        f = bus.o_data[o*FW +: FW];
        if (prev_hold[o]) begin
          n_checks++;
          if (bus.o_data_valid[o] !== 1'b1 || f !== prev_data[o]) begin
            n_fail++; $display("FAIL rand_hold[%0d]: got v=%b d=%h expected v=1 d=%h",
                               o, bus.o_data_valid[o], f, prev_data[o]);
          end
        end
        if (bus.o_data_valid[o] && rdy[o]) begin
          s   = int'(f[DW-1 -: 4]);
          idx = -1;
          for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].src == s && exp_q[i].port == o) begin
              idx = i;
              break;
            end
          end
          n_checks++;
          if (idx < 0) begin
            n_fail++; $display("FAIL rand_unexpected[%0d]: got %h expected no flit", o, f);
          end else begin
            if (exp_q[idx].flit !== f) begin
              n_fail++; $display("FAIL rand_order[%0d]: got %h expected %h", o, f, exp_q[idx].flit);
            end
            exp_q.delete(idx);
          end
        end
        prev_hold[o] = bus.o_data_valid[o] && !rdy[o];
        prev_data[o] = f;
      end
      // ingress side
      for (int p = 0; p < P; p++) begin
        if (!has_pend[p] && created < N_RANDOM && $urandom_range(0, 2) != 0) begin
          pend_flit[p] = mk(int'($urandom_range(0, 7)), {4'(p), 28'(seq)});
          seq++;
          created++;
          has_pend[p] = 1'b1;
        end
        bus.i_data_valid[p]    = has_pend[p];
        bus.i_data[p*FW +: FW] = pend_flit[p];
        if (has_pend[p] && bus.o_data_ready[p]) begin
          rp = ref_port(p, int'(pend_flit[p][FW-1 -: AW]));
          if (rp < 0) drop_exp++;
          else exp_q.push_back('{flit: pend_flit[p], src: p, port: rp});
          has_pend[p] = 1'b0;
          injected++;
        end
      end
      if (created == N_RANDOM && has_pend == '0 && exp_q.size() == 0) done = 1'b1;
      tick();
    end
    idle_inputs();
    repeat (10) tick();
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL rand_timeout: got %0d outstanding, %0d accepted expected %0d",
                         exp_q.size(), injected, N_RANDOM);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_lost: got %0d undelivered expected 0", exp_q.size());
    end
    n_checks++;
    if (drop_count !== 16'(drop_exp)) begin
      n_fail++; $display("FAIL rand_drop: got %0d expected %0d", drop_count, drop_exp);
    end
    n_checks++;
    if (bus.o_data_valid !== '0) begin
      n_fail++; $display("FAIL rand_idle: got %b expected 0", bus.o_data_valid);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_rr();
    test_backpressure();
    test_routing_and_drop();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
